// File: rtl/sdram_port_arbiter.sv
// Single-port SDRAM arbiter: loader writes (strict priority) vs bg/obj reads (round-robin).
// Optional WAIT watchdog with sticky err port when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
  parameter int AW          = 25,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ack,
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic [DW-1:0] bg_data,
  output logic          bg_rdy,
  input  logic          obj_req,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_rdy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,output logic         err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {CH_LD, CH_BG, CH_OBJ} chan_t;

  state_t        state, state_nx;
  chan_t         gnt, gnt_nx;
  logic          rr_bg;   // 1: bg wins the next bg/obj tie
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          tmo;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign tmo = (state == S_WAIT) && !mem_ready && (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    case (state)
      S_IDLE: begin
        if (ld_req) begin
          gnt_nx   = CH_LD;
          state_nx = S_ISSUE;
        end else if (bg_req && obj_req) begin
          gnt_nx   = rr_bg ? CH_BG : CH_OBJ;
          state_nx = S_ISSUE;
        end else if (bg_req) begin
          gnt_nx   = CH_BG;
          state_nx = S_ISSUE;
        end else if (obj_req) begin
          gnt_nx   = CH_OBJ;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mem_ready || tmo) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      gnt   <= CH_LD;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_q   <= '0;
      din_q    <= '0;
      bg_data  <= '0;
      obj_data <= '0;
      rr_bg    <= 1'b1;
    end else begin
      if (state == S_IDLE && state_nx == S_ISSUE) begin
        case (gnt_nx)
          CH_LD:   begin addr_q <= ld_addr; din_q <= ld_data; end
          CH_BG:   addr_q <= bg_addr;
          default: addr_q <= obj_addr;
        endcase
      end
      // A timed-out read returns all-ones so the consumer sees an obvious pattern.
      if (state == S_WAIT && (mem_ready || tmo)) begin
        if (gnt == CH_BG)  bg_data  <= mem_ready ? mem_dout : {DW{1'b1}};
        if (gnt == CH_OBJ) obj_data <= mem_ready ? mem_dout : {DW{1'b1}};
      end
      if (state == S_DONE && gnt != CH_LD) rr_bg <= (gnt == CH_OBJ);
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (tmo) err <= 1'b1;
    end
  end
`endif

  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = (state == S_ISSUE) && (gnt == CH_LD);
  assign mem_rd   = (state == S_ISSUE) && (gnt != CH_LD);
  assign ld_ack   = (state == S_DONE)  && (gnt == CH_LD);
  assign bg_rdy   = (state == S_DONE)  && (gnt == CH_BG);
  assign obj_rdy  = (state == S_DONE)  && (gnt == CH_OBJ);

endmodule
